ifetch_ctrl: RTL and testbench

Instruction-fetch controller sitting directly upstream of the fetch/decode stage. It owns the architectural fetch PC and issues one instruction-bus request at a time. It captures the returned 32-bit instruction word into a one-entry output buffer and presents {raw_instr, pc} with a valid/ready handshake to the decode stage. Redirects from later stages (branch/jump resolution) re-steer the PC and squash in-flight or buffered instructions.

---
 rtl/ifetch_ctrl.sv | 98 +++++++++
 tb/tb_ifetch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, issues one bus request at a
// time and hands {raw_instr, pc} to decode through a one-entry output buffer.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] raw_instr,
  output logic [63:0] pc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [63:0] fetch_pc;
  logic [63:0] req_addr;
  logic        kill;
  logic        complete;
  logic        capture;
  logic        in_flight;

  // A response completes the single outstanding access; it is kept only if
  // no redirect has overtaken it (earlier or in this very cycle).
  assign complete  = ((state == S_REQ)  && iresp_addr_ok && iresp_data_ok) ||
                     ((state == S_WAIT) && iresp_data_ok);
  assign capture   = complete && !kill && !redirect_valid;
  assign in_flight = (state == S_REQ) || (state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (!redirect_valid && (!out_valid || out_ready)) state_nxt = S_REQ;
      S_REQ: begin
        if (iresp_addr_ok && iresp_data_ok) state_nxt = S_IDLE;
        else if (iresp_addr_ok)             state_nxt = S_WAIT;
      end
      S_WAIT: if (iresp_data_ok) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ireq_valid = (state == S_REQ);
    ireq_addr  = req_addr;
  end

  // The request address is latched separately so a redirect during REQ can
  // move fetch_pc while the bus still sees the original, stable address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc  <= RESET_PC;
      req_addr  <= RESET_PC;
      kill      <= 1'b0;
      out_valid <= 1'b0;
      raw_instr <= '0;
      pc        <= '0;
    end else begin
      if ((state == S_IDLE) && (state_nxt == S_REQ)) req_addr <= fetch_pc;

      if (redirect_valid) fetch_pc <= redirect_pc & ~64'h3;
      else if (capture)   fetch_pc <= fetch_pc + 64'd4;

      // A response landing in the redirect cycle already consumes the access.
      if (redirect_valid) kill <= in_flight && !complete;
      else if (complete)  kill <= 1'b0;

      if (redirect_valid)                out_valid <= 1'b0;
      else if (capture)                  out_valid <= 1'b1;
      else if (out_valid && out_ready)   out_valid <= 1'b0;

      if (capture) begin
        raw_instr <= iresp_data;
        pc        <= fetch_pc;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    capture |-> !out_valid);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: cycle-by-cycle bus stimulus with
// hand-computed expected request addresses and buffer contents.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] raw_instr;
  logic [63:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  ifetch_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .raw_instr      (raw_instr),
    .pc             (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a REQ cycle: zero-wait response, then checks the capture.
  task automatic fetch_zw(input string tag, input logic [63:0] addr, input logic [31:0] d);
    check({tag, "_req_valid"}, 64'(ireq_valid), 64'd1);
    check({tag, "_req_addr"}, ireq_addr, addr);
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = d;
    tick();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_raw_instr"}, 64'(raw_instr), 64'(d));
    check({tag, "_pc"}, pc, addr);
    check({tag, "_req_idle"}, 64'(ireq_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113;

    resetn         = 1'b0;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 64'(ireq_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_raw_instr", 64'(raw_instr), 64'd0);
    check("rst_pc", pc, 64'd0);
    resetn = 1'b1;
    tick();

    // Zero-wait bus, decode always ready: one instruction every two cycles.
    for (int i = 0; i < 3; i++) begin
      fetch_zw($sformatf("zw%0d", i), 64'h8000_0000 + 64'(4 * i), words[i]);
      if (i < 2) begin
        tick();
        check($sformatf("zw%0d_consumed", i), 64'(out_valid), 64'd0);
      end
    end

    // Back-pressure: buffer held, no new request.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_raw_instr", 64'(raw_instr), 64'h0020_0113);
      check("bp_pc", pc, 64'h8000_0008);
      check("bp_no_req", 64'(ireq_valid), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_rel_req", 64'(ireq_valid), 64'd1);
    check("bp_rel_addr", ireq_addr, 64'h8000_000C);
    check("bp_rel_out_valid", 64'(out_valid), 64'd0);

    // addr_ok delayed three cycles, data two cycles after acceptance.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("slow_req_held", 64'(ireq_valid), 64'd1);
      check("slow_addr_held", ireq_addr, 64'h8000_000C);
    end
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    check("slow_wait_req", 64'(ireq_valid), 64'd0);
    tick();
    check("slow_wait_out", 64'(out_valid), 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h0030_0193;
    tick();
    iresp_data_ok = 1'b0;
    check("slow_out_valid", 64'(out_valid), 64'd1);
    check("slow_raw_instr", 64'(raw_instr), 64'h0030_0193);
    check("slow_pc", pc, 64'h8000_000C);
    tick();
    check("slow_next_addr", ireq_addr, 64'h8000_0010);

    // Redirect while WAIT: the late response is dropped.
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    check("rw_no_req", 64'(ireq_valid), 64'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hDEAD_BEEF;
    tick();
    iresp_data_ok = 1'b0;
    check("rw_dropped", 64'(out_valid), 64'd0);
    tick();
    fetch_zw("rw_target", 64'h8000_1000, 32'h0040_0213);

    // Redirect with a full, stalled buffer and a stray data_ok in that cycle.
    out_ready = 1'b0;
    tick();
    check("rf_held", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hBAD0_0001;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    check("rf_flushed", 64'(out_valid), 64'd0);
    check("rf_hold_idle", 64'(ireq_valid), 64'd0);
    tick();
    check("rf_req", 64'(ireq_valid), 64'd1);
    check("rf_addr", ireq_addr, 64'h8000_2000);

    // Redirect coinciding with data_ok in WAIT: nothing left to kill afterwards.
    out_ready     = 1'b1;
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hBAD0_0002;
    tick();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    check("rd_dropped", 64'(out_valid), 64'd0);
    tick();
    fetch_zw("rd_target", 64'h8000_3000, 32'h0050_0293);

    // Asynchronous reset in WAIT.
    tick();
    check("ar_addr", ireq_addr, 64'h8000_3004);
    iresp_addr_ok = 1'b1;
    tick();
    iresp_addr_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("ar_req_valid", 64'(ireq_valid), 64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_raw_instr", 64'(raw_instr), 64'd0);
    check("ar_pc", pc, 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("ar_req_after", 64'(ireq_valid), 64'd1);
    check("ar_addr_after", ireq_addr, 64'h8000_0000);

    // Redirect in REQ before addr_ok: old address held, access killed.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_4000;
    tick();
    redirect_valid = 1'b0;
    check("rq_req_held", 64'(ireq_valid), 64'd1);
    check("rq_addr_held", ireq_addr, 64'h8000_0000);
    iresp_addr_ok = 1'b1;
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hBAD0_0003;
    tick();
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    check("rq_dropped", 64'(out_valid), 64'd0);
    tick();
    fetch_zw("rq_target", 64'h8000_4000, 32'h0060_0313);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
